// File: rtl/int_ctrl.sv
// Interrupt controller: edge-detects request lines, masks and prioritises them,
// and sequences one take/service/return cycle at a time for the return-address stack.
module int_ctrl #(
  parameter int          NIRQ     = 4,
  parameter logic [9:0]  VEC_BASE = 10'h3C0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_d,
  input  logic            reti,
  input  logic            stack_overflow,
  output logic            int_take,
  output logic [9:0]      vector,
  output logic            int_ret,
  output logic            in_service,
  output logic [NIRQ-1:0] pending,
  output logic            reti_err,
  output logic [1:0]      o_dbg_state
);

  localparam int IDW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  // Encoding is visible on o_dbg_state: 0 = IDLE, 1 = TAKE, 2 = SERVICE.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          r_state;
  logic [NIRQ-1:0] r_irq_q;
  logic [NIRQ-1:0] r_pending;
  logic [NIRQ-1:0] r_mask;
  logic            r_int_take;
  logic            r_in_service;
  logic            r_reti_err;
  logic [9:0]      r_vector;

  logic [NIRQ-1:0] w_edge;
  logic [NIRQ-1:0] w_req;
  logic [NIRQ-1:0] w_clr;
  logic [IDW-1:0]  w_id;
  logic            w_found;
  logic            w_take_now;

  assign w_edge = irq & ~r_irq_q;
  assign w_req  = r_pending & r_mask;

  // Scan downwards so the lowest requesting index is the one left standing.
  always_comb begin
    w_id    = '0;
    w_found = 1'b0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_id    = IDW'(i);
        w_found = 1'b1;
      end
    end
  end

  assign w_take_now = (r_state == IDLE) && w_found && !stack_overflow;
  assign w_clr      = w_take_now ? (NIRQ'(1) << w_id) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_irq_q      <= irq;
      r_pending    <= '0;
      r_mask       <= '0;
      r_int_take   <= 1'b0;
      r_in_service <= 1'b0;
      r_reti_err   <= 1'b0;
      r_vector     <= VEC_BASE;
    end else begin
      r_irq_q    <= irq;
      // A fresh edge on the line being taken re-arms it: set wins over clear.
      r_pending  <= (r_pending & ~w_clr) | w_edge;
      r_int_take <= 1'b0;
      if (mask_we) begin
        r_mask <= mask_d;
      end
      if (reti && (r_state != SERVICE)) begin
        r_reti_err <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_take_now) begin
            r_state      <= TAKE;
            r_int_take   <= 1'b1;
            r_in_service <= 1'b1;
            r_vector     <= VEC_BASE + (10'(w_id) << 2);
          end
        end
        TAKE: begin
          r_state <= SERVICE;
        end
        SERVICE: begin
          if (reti) begin
            r_state      <= IDLE;
            r_in_service <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_in_service <= 1'b0;
        end
      endcase
    end
  end

  // Combinational so the stack sees it in the same cycle as the decoder's pop.
  assign int_ret     = reti && (r_state == SERVICE);
  assign int_take    = r_int_take;
  assign vector      = r_vector;
  assign in_service  = r_in_service;
  assign pending     = r_pending;
  assign reti_err    = r_reti_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: per-cycle vector rows feed a scoreboard queue; a second
// instance with VEC_BASE=10'h3FC shares the stimulus to exercise vector wrap-around.
module tb_int_ctrl;

  typedef struct {
    logic       rst;
    logic [3:0] irq;
    logic       mwe;
    logic [3:0] md;
    logic       reti;
    logic       ovf;
    logic       take;
    logic       iret;
    logic       insv;
    logic [3:0] pend;
    logic       err;
    logic       vchk;
    logic [9:0] vec;
    logic [9:0] vec2;
  } row_t;

  localparam int EW = 29;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_d;
  logic       reti;
  logic       stack_overflow;

  logic       take1, iret1, insv1, err1;
  logic [9:0] vec1;
  logic [3:0] pend1;
  logic [1:0] st1;
  logic       take2, iret2, insv2, err2;
  logic [9:0] vec2;
  logic [3:0] pend2;
  logic [1:0] st2;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  row_t tbl[23];

  always #5 clk = ~clk;

  int_ctrl #(.NIRQ(4), .VEC_BASE(10'h3C0)) u_dut (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_d(mask_d),
    .reti(reti), .stack_overflow(stack_overflow),
    .int_take(take1), .vector(vec1), .int_ret(iret1), .in_service(insv1),
    .pending(pend1), .reti_err(err1), .o_dbg_state(st1)
  );

  int_ctrl #(.NIRQ(4), .VEC_BASE(10'h3FC)) u_dut2 (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_d(mask_d),
    .reti(reti), .stack_overflow(stack_overflow),
    .int_take(take2), .vector(vec2), .int_ret(iret2), .in_service(insv2),
    .pending(pend2), .reti_err(err2), .o_dbg_state(st2)
  );

  function automatic row_t mk(input logic rst, input logic [3:0] i_irq, input logic mwe,
                              input logic [3:0] md, input logic rt, input logic ovf,
                              input logic tk, input logic ir, input logic sv,
                              input logic [3:0] pd, input logic er, input logic vc,
                              input logic [9:0] v1, input logic [9:0] v2);
    row_t r;
    r.rst = rst; r.irq = i_irq; r.mwe = mwe; r.md = md; r.reti = rt; r.ovf = ovf;
    r.take = tk; r.iret = ir; r.insv = sv; r.pend = pd; r.err = er;
    r.vchk = vc; r.vec = v1; r.vec2 = v2;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs just after the edge, compare outputs at the falling edge.
  task automatic run_row(input row_t r);
    logic [EW-1:0] e;
    logic [1:0]    est;
    @(posedge clk);
    #1;
    reset = r.rst; irq = r.irq; mask_we = r.mwe; mask_d = r.md;
    reti = r.reti; stack_overflow = r.ovf;
    exp_q.push_back({r.take, r.iret, r.insv, r.pend, r.err, r.vchk, r.vec, r.vec2});
    @(negedge clk);
    e   = exp_q.pop_front();
    est = e[28] ? 2'd1 : (e[26] ? 2'd2 : 2'd0);
    chk("int_take",   {31'd0, take1}, {31'd0, e[28]});
    chk("int_ret",    {31'd0, iret1}, {31'd0, e[27]});
    chk("in_service", {31'd0, insv1}, {31'd0, e[26]});
    chk("pending",    {28'd0, pend1}, {28'd0, e[25:22]});
    chk("reti_err",   {31'd0, err1},  {31'd0, e[21]});
    chk("state",      {30'd0, st1},   {30'd0, est});
    chk("int_take_b", {31'd0, take2}, {31'd0, e[28]});
    chk("int_ret_b",  {31'd0, iret2}, {31'd0, e[27]});
    chk("in_svc_b",   {31'd0, insv2}, {31'd0, e[26]});
    chk("pending_b",  {28'd0, pend2}, {28'd0, e[25:22]});
    chk("reti_err_b", {31'd0, err2},  {31'd0, e[21]});
    chk("state_b",    {30'd0, st2},   {30'd0, est});
    if (e[20]) begin
      chk("vector",     {22'd0, vec1}, {22'd0, e[19:10]});
      chk("vector_wrap", {22'd0, vec2}, {22'd0, e[9:0]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; irq = '0; mask_we = 1'b0; mask_d = '0; reti = 1'b0; stack_overflow = 1'b0;
    repeat (2) @(posedge clk);

    //           rst irq     mwe md      rt ov  tk ir sv pend    er vc vec     vec2
    tbl[0]  = mk(1, 4'b0000, 0, 4'b0000, 0, 0,  0, 0, 0, 4'b0000, 0, 1, 10'h3C0, 10'h3FC);
    tbl[1]  = mk(0, 4'b0000, 1, 4'b0001, 0, 0,  0, 0, 0, 4'b0000, 0, 1, 10'h3C0, 10'h3FC);
    tbl[2]  = mk(0, 4'b0001, 0, 4'b0000, 0, 0,  0, 0, 0, 4'b0000, 0, 0, 10'h000, 10'h000);
    tbl[3]  = mk(0, 4'b0001, 0, 4'b0000, 0, 0,  0, 0, 0, 4'b0001, 0, 0, 10'h000, 10'h000);
    tbl[4]  = mk(0, 4'b0000, 0, 4'b0000, 0, 0,  1, 0, 1, 4'b0000, 0, 1, 10'h3C0, 10'h3FC);
    tbl[5]  = mk(0, 4'b0000, 0, 4'b0000, 0, 0,  0, 0, 1, 4'b0000, 0, 0, 10'h000, 10'h000);
    tbl[6]  = mk(0, 4'b0000, 0, 4'b0000, 1, 0,  0, 1, 1, 4'b0000, 0, 0, 10'h000, 10'h000);
    tbl[7]  = mk(0, 4'b0000, 0, 4'b0000, 0, 0,  0, 0, 0, 4'b0000, 0, 0, 10'h000, 10'h000);
    tbl[8]  = mk(0, 4'b0000, 0, 4'b0000, 1, 0,  0, 0, 0, 4'b0000, 0, 0, 10'h000, 10'h000);
    tbl[9]  = mk(0, 4'b0000, 0, 4'b0000, 0, 0,  0, 0, 0, 4'b0000, 1, 0, 10'h000, 10'h000);
    tbl[10] = mk(0, 4'b0000, 1, 4'b1111, 0, 0,  0, 0, 0, 4'b0000, 1, 0, 10'h000, 10'h000);
    tbl[11] = mk(0, 4'b1010, 0, 4'b0000, 0, 0,  0, 0, 0, 4'b0000, 1, 0, 10'h000, 10'h000);
    tbl[12] = mk(0, 4'b1010, 0, 4'b0000, 0, 0,  0, 0, 0, 4'b1010, 1, 0, 10'h000, 10'h000);
    tbl[13] = mk(0, 4'b0000, 0, 4'b0000, 0, 0,  1, 0, 1, 4'b1000, 1, 1, 10'h3C4, 10'h000);
    tbl[14] = mk(0, 4'b0000, 0, 4'b0000, 0, 0,  0, 0, 1, 4'b1000, 1, 0, 10'h000, 10'h000);
    tbl[15] = mk(0, 4'b0000, 0, 4'b0000, 1, 0,  0, 1, 1, 4'b1000, 1, 0, 10'h000, 10'h000);
    tbl[16] = mk(0, 4'b0000, 0, 4'b0000, 0, 0,  0, 0, 0, 4'b1000, 1, 0, 10'h000, 10'h000);
    tbl[17] = mk(0, 4'b0000, 0, 4'b0000, 0, 0,  1, 0, 1, 4'b0000, 1, 1, 10'h3CC, 10'h008);
    tbl[18] = mk(0, 4'b0000, 0, 4'b0000, 0, 0,  0, 0, 1, 4'b0000, 1, 0, 10'h000, 10'h000);
    tbl[19] = mk(0, 4'b0000, 0, 4'b0000, 1, 0,  0, 1, 1, 4'b0000, 1, 0, 10'h000, 10'h000);
    tbl[20] = mk(0, 4'b0000, 1, 4'b0000, 0, 0,  0, 0, 0, 4'b0000, 1, 0, 10'h000, 10'h000);
    tbl[21] = mk(0, 4'b0100, 0, 4'b0000, 0, 0,  0, 0, 0, 4'b0000, 1, 0, 10'h000, 10'h000);
    tbl[22] = mk(0, 4'b0000, 0, 4'b0000, 0, 0,  0, 0, 0, 4'b0100, 1, 0, 10'h000, 10'h000);
    for (int i = 0; i < 23; i++) run_row(tbl[i]);

    // Masked request waits, then unmasking makes it eligible.
    for (int i = 0; i < 20; i++)
      run_row(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0100, 1, 0, 10'h000, 10'h000));
    run_row(mk(0, 4'b0000, 1, 4'b0100, 0, 0, 0, 0, 0, 4'b0100, 1, 0, 10'h000, 10'h000));
    run_row(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0100, 1, 0, 10'h000, 10'h000));
    run_row(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 0, 1, 4'b0000, 1, 1, 10'h3C8, 10'h004));
    run_row(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 1, 0, 10'h000, 10'h000));
    run_row(mk(0, 4'b0000, 0, 4'b0000, 1, 0, 0, 1, 1, 4'b0000, 1, 0, 10'h000, 10'h000));
    run_row(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 1, 0, 10'h000, 10'h000));

    // Stack overflow holds an enabled pending request in IDLE.
    run_row(mk(0, 4'b0001, 1, 4'b0001, 0, 1, 0, 0, 0, 4'b0000, 1, 0, 10'h000, 10'h000));
    run_row(mk(0, 4'b0001, 0, 4'b0000, 0, 1, 0, 0, 0, 4'b0001, 1, 0, 10'h000, 10'h000));
    for (int i = 0; i < 10; i++)
      run_row(mk(0, 4'b0000, 0, 4'b0000, 0, 1, 0, 0, 0, 4'b0001, 1, 0, 10'h000, 10'h000));
    run_row(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0001, 1, 0, 10'h000, 10'h000));
    run_row(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 0, 1, 4'b0000, 1, 1, 10'h3C0, 10'h3FC));
    run_row(mk(0, 4'b0010, 0, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 1, 0, 10'h000, 10'h000));

    // Reset while in SERVICE with a masked request pending.
    run_row(mk(1, 4'b0010, 0, 4'b0000, 0, 0, 0, 0, 1, 4'b0010, 1, 0, 10'h000, 10'h000));
    run_row(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 10'h3C0, 10'h3FC));
    run_row(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 10'h3C0, 10'h3FC));

    // Lines held high through reset produce no edge afterwards.
    run_row(mk(1, 4'b1111, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 10'h000, 10'h000));
    run_row(mk(1, 4'b1111, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 10'h3C0, 10'h3FC));
    for (int i = 0; i < 3; i++)
      run_row(mk(0, 4'b1111, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 10'h3C0, 10'h3FC));

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
